// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: condition select, target/link generation,
// redirect handshake and post-redirect squash window. Optional stats under BRANCH_STATS_EN.
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            eq,
    input  logic            ne,
    input  logic            lt,
    input  logic            ge,
    input  logic            ltu,
    input  logic            geu,
    input  logic            kill,
    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_link,
    output logic            res_illegal,
    output logic            res_misalign,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            squash
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispredict_free
`endif
);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cond, f3_illegal, xfer, misalign, taken, accept;
    logic [XLEN-1:0] jalr_sum, target;

    always_comb begin
        cond       = 1'b0;
        f3_illegal = 1'b0;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ne;
            3'b100:  cond = lt;
            3'b101:  cond = ge;
            3'b110:  cond = ltu;
            3'b111:  cond = geu;
            default: f3_illegal = 1'b1;
        endcase
        jalr_sum = rs1_val + imm;
        target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
        xfer     = is_jal | is_jalr | (is_branch & cond);
        misalign = xfer & (target[1:0] != 2'b00);
        taken    = xfer & ~misalign;
    end

    assign in_ready       = (state_q == IDLE) & ~kill;
    assign accept         = in_valid & in_ready;
    assign redirect_valid = (state_q == REDIRECT);
    assign squash         = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && taken) state_d = REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state_d = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
                        cnt_d   = 4'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    // Last squash cycle is the one where the counter reads 1.
                    if (cnt_q <= 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result stage: redirect_pc only reloads on accept, which keeps it stable through REDIRECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_taken    <= 1'b0;
            res_illegal  <= 1'b0;
            res_misalign <= 1'b0;
            res_link     <= '0;
            redirect_pc  <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_taken    <= taken;
                res_illegal  <= is_branch & f3_illegal;
                res_misalign <= misalign;
                res_link     <= pc + XLEN'(4);
                redirect_pc  <= target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches        <= '0;
            stat_taken           <= '0;
            stat_mispredict_free <= '0;
        end else if (accept) begin
            if (is_branch)          stat_branches        <= sat_inc(stat_branches);
            if (taken)              stat_taken           <= sat_inc(stat_taken);
            if (is_branch && !taken) stat_mispredict_free <= sat_inc(stat_mispredict_free);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios then random traffic against a reference model.
module tb_branch_resolve;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, is_branch, is_jal, is_jalr;
    logic [2:0] funct3;
    logic [31:0] pc, imm, rs1_val;
    logic eq, ne, lt, ge, ltu, geu, kill;
    logic res_valid, res_taken, res_illegal, res_misalign;
    logic [31:0] res_link, redirect_pc;
    logic redirect_valid, redirect_ready, squash;

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
        .pc(pc), .imm(imm), .rs1_val(rs1_val),
        .eq(eq), .ne(ne), .lt(lt), .ge(ge), .ltu(ltu), .geu(geu),
        .kill(kill), .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
        .res_illegal(res_illegal), .res_misalign(res_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .squash(squash)
    );

    typedef struct {
        int unsigned cyc;
        logic        taken, illegal, misalign, chk_link, chk_tgt;
        logic [31:0] link, tgt;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int checks = 0, passes = 0;
    int g_kind = 0;
    logic [2:0] g_f3;
    logic [31:0] g_a, g_b;
    bit m_redir = 0;
    int m_flush = 0;
    logic [31:0] m_rpc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: branch outcome from the operand values themselves.
    function automatic exp_t model(input int kind, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] p,
                                   input logic [31:0] im, input logic [31:0] r1);
        exp_t e;
        logic c, x;
        logic [31:0] t;
        c = 1'b0;
        e.cyc = 0;
        e.illegal = 1'b0;
        if (kind == 1) begin
            case (f3)
                3'd0: c = (a == b);
                3'd1: c = (a != b);
                3'd4: c = ($signed(a) < $signed(b));
                3'd5: c = ($signed(a) >= $signed(b));
                3'd6: c = (a < b);
                3'd7: c = (a >= b);
                default: e.illegal = 1'b1;
            endcase
        end
        x = (kind == 1 && c) || kind == 2 || kind == 3;
        t = (kind == 3) ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
        e.misalign = x && (t % 4 != 0);
        e.taken    = x && (t % 4 == 0);
        e.tgt      = t;
        e.chk_tgt  = x;
        e.link     = p + 32'd4;
        e.chk_link = (kind >= 2);
        return e;
    endfunction

    task automatic set_instr(input int kind, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] p,
                             input logic [31:0] im, input logic [31:0] r1);
        g_kind = kind; g_f3 = f3; g_a = a; g_b = b;
        is_branch = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
        funct3 = f3; pc = p; imm = im; rs1_val = r1;
        eq = (a == b); ne = (a != b);
        lt = ($signed(a) < $signed(b)); ge = ~lt;
        ltu = (a < b); geu = ~ltu;
    endtask

    // One cycle: check control outputs, enqueue any accepted instruction, advance the model.
    task automatic tick();
        exp_t e;
        bit acc;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!m_redir && m_flush == 0 && !kill));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        chk("squash", 32'(squash), 32'(m_redir || m_flush > 0));
        if (m_redir) chk("redirect_pc_hold", redirect_pc, m_rpc);
        acc = !rst && in_valid && !m_redir && m_flush == 0 && !kill;
        e = model(g_kind, g_f3, g_a, g_b, pc, imm, rs1_val);
        if (acc) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (rst || kill) begin
            m_redir = 0; m_flush = 0;
        end else if (m_redir) begin
            if (redirect_ready) begin m_redir = 0; m_flush = FC; end
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (acc && e.taken) begin
            m_redir = 1; m_rpc = e.tgt;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("res_latency", cyc, e.cyc + 1);
                chk("res_taken", 32'(res_taken), 32'(e.taken));
                chk("res_illegal", 32'(res_illegal), 32'(e.illegal));
                chk("res_misalign", 32'(res_misalign), 32'(e.misalign));
                if (e.chk_link) chk("res_link", res_link, e.link);
                if (e.chk_tgt) chk("target", redirect_pc, e.tgt);
            end
        end
    end

    initial begin
        rst = 1; in_valid = 0; kill = 0; redirect_ready = 0;
        set_instr(0, 3'd0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_taken", 32'(res_taken), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_squash", 32'(squash), 32'd0);

        // BEQ taken, redirect accepted at once, then squash window
        set_instr(1, 3'd0, 5, 5, 32'h100, 32'h20, 0); in_valid = 1; tick();
        in_valid = 0; redirect_ready = 1;
        chk("t1_redirect_pc", redirect_pc, 32'h120);
        tick(); redirect_ready = 0; tick(); tick(); tick();

        // Not-taken BLTU then back-to-back BNE
        set_instr(1, 3'd6, 5, 3, 32'h140, 32'h10, 0); in_valid = 1; tick();
        set_instr(1, 3'd1, 7, 7, 32'h144, 32'h10, 0); tick();
        in_valid = 0; tick(); tick();

        // JALR misaligned, then JALR aligned with bit0 cleared
        set_instr(3, 3'd0, 0, 0, 32'h200, 0, 32'h1003); in_valid = 1; tick();
        set_instr(3, 3'd0, 0, 0, 32'h204, 0, 32'h1001); tick();
        in_valid = 0; tick(); redirect_ready = 1; tick(); redirect_ready = 0;
        repeat (3) tick();

        // Redirect stalled, then killed
        set_instr(1, 3'd0, 1, 1, 32'h300, 32'h40, 0); in_valid = 1; tick();
        in_valid = 0; tick(); tick();
        kill = 1; redirect_ready = 1; tick(); kill = 0; redirect_ready = 0;
        tick(); tick();

        // Illegal funct3, then wrap-around target
        set_instr(1, 3'd2, 1, 1, 32'h380, 32'h8, 0); in_valid = 1; tick();
        set_instr(1, 3'd0, 9, 9, 32'hFFFF_FFFC, 32'h8, 0); tick();
        in_valid = 0; chk("t5_wrap_pc", redirect_pc, 32'h4);
        redirect_ready = 1; tick(); redirect_ready = 0; repeat (3) tick();

        // Reset during FLUSH
        set_instr(2, 3'd0, 0, 0, 32'h400, 32'h10, 0); in_valid = 1; tick();
        in_valid = 0; redirect_ready = 1; tick(); redirect_ready = 0; tick();
        rst = 1; tick(); rst = 0;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_squash", 32'(squash), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_res_taken", 32'(res_taken), 32'd0);
        chk("t6_redirect_pc", redirect_pc, 32'd0);
        tick();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_instr(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, b,
                      $urandom & 32'hFFFF_FFFC,
                      ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFE) : 32'($urandom_range(0, 15) * 2),
                      $urandom);
            in_valid       = ($urandom_range(0, 3) != 0);
            kill           = ($urandom_range(0, 11) == 0);
            redirect_ready = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; in_valid = 0; kill = 0; redirect_ready = 1;
        repeat (10) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution unit for the RV32 core; sits directly downstream of the branch condition generator.
- Consumes its eq/ne/lt/ge/ltu/geu flags plus decoded control-transfer fields, and decides taken/not-taken.
- Computes the target and link address.
- Drives a redirect handshake to fetch and squashes younger pipeline stages for a fixed number of cycles after a taken transfer.

Parameters:
- XLEN, 32, datapath/address width
- FLUSH_CYCLES, 2, cycles squash held high after redirect is accepted (0..15)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  instruction present this cycle
- in_ready  output  1  unit can accept (state IDLE and no external kill)
- is_branch  input  1  conditional branch
- is_jal  input  1  JAL
- is_jalr  input  1  JALR
- funct3  input  3  branch condition select
- pc  input  XLEN  instruction address
- imm  input  XLEN  sign-extended immediate
- rs1_val  input  XLEN  JALR base
- eq, ne, lt, ge, ltu, geu  input  1 each  condition flags for rs1 vs rs2
- kill  input  1  external flush (trap/older redirect), highest priority
- res_valid  output  1  one-cycle pulse, result registered
- res_taken  output  1  transfer taken
- res_link  output  XLEN  pc+4 (valid for JAL/JALR)
- res_illegal  output  1  funct3 010/011 on a branch
- res_misalign  output  1  taken target[1:0] != 0
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  XLEN  new fetch address
- redirect_ready  input  1  fetch accepts redirect
- squash  output  1  kill younger stages

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1; flush counter 0. Reset mid-operation abandons any pending redirect/flush without a res_valid pulse.
- Accept: in_valid && in_ready. Exactly one of is_branch/is_jal/is_jalr must be high. If none is high, the instruction passes through with res_valid=1 and res_taken=0.
- Condition decode (is_branch):
  - 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
  - 010/011: not taken, res_illegal=1.
- JAL and JALR are always taken.
- Targets:
  - Branch/JAL: pc+imm.
  - JALR: (rs1_val+imm) with bit0 cleared.
  - All arithmetic is modulo 2^XLEN; wrap-around is legal.
- Misalignment: if taken and target[1]=1, set res_misalign=1, res_taken=0, and issue no redirect (trap handled elsewhere).
- Latency: results are registered; res_valid pulses on the cycle after accept.
- State machine:
  - IDLE: on accept, go to REDIRECT if the transfer is taken and aligned; otherwise stay in IDLE.
  - REDIRECT:
    - redirect_valid=1; redirect_pc is held stable and squash=1.
    - When redirect_ready is sampled high, go to FLUSH and load the counter with FLUSH_CYCLES.
    - If FLUSH_CYCLES=0, go directly to IDLE instead.
    - redirect_valid must not drop before redirect_ready is seen.
  - FLUSH: squash=1; decrement the counter each cycle; go to IDLE on the cycle the counter reaches 1.
- in_ready=1 only in IDLE with kill=0.
- kill:
  - In any state, the next state is IDLE; redirect_valid and squash drop next cycle; the counter clears.
  - An instruction offered in the same cycle as kill is not accepted.
  - If kill coincides with redirect_ready, the kill wins and the redirect counts as consumed.
  - A res_valid already registered still pulses.
- Back-to-back: the next accept is possible in the cycle after returning to IDLE.
- Not-taken branches never leave IDLE, so they accept every cycle.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs stat_branches, stat_taken, stat_mispredict_free (32 bits each):
  - stat_branches counts accepted is_branch.
  - stat_taken counts taken, aligned transfers.
  - stat_mispredict_free counts not-taken branches.
  - All three clear on rst and saturate at all-ones.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. BEQ, pc=0x100, imm=0x20, eq=1 -> next cycle res_valid=1, res_taken=1, redirect_valid=1, redirect_pc=0x120. redirect_ready on that cycle -> squash high for 2 more cycles, then in_ready=1.
2. BLTU with ltu=0 -> res_taken=0, no redirect, in_ready stays 1. Back-to-back BNE with ne=0 is accepted on the next cycle.
3. JALR, rs1_val=0x1003, imm=0 -> redirect_pc=0x1002, res_misalign=1, res_taken=0, no redirect. JALR, rs1_val=0x1001 -> redirect_pc=0x1000, res_link=pc+4.
4. Redirect held with redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable, in_ready=0. kill asserted on cycle 3 -> IDLE next cycle, squash=0.
5. Branch with funct3=010 -> res_illegal=1, not taken. pc=0xFFFFFFFC, imm=8, taken -> redirect_pc=0x00000004.
6. rst asserted during FLUSH -> next cycle all outputs 0 and in_ready=1. With BRANCH_STATS_EN, counters read 0.
